tdnn_layer_seq: RTL and testbench
=================================

# tdnn_layer_seq

Parametrised, time-multiplexed time-delay neural network layer: successor to the fixed two-signal TDNN core. It keeps a NUM_INPUTS-deep delay line per input channel and computes NUM_SIGS outputs, each a fully cross-channel weighted sum, using a single shared signed multiplier-accumulator. It adds a ready/valid sample handshake, a runtime-writable weight bank, output saturation, and a bypass mode. It sits between the switch/sample source and the Seg7 display driver.

## Interface
- SIG_SIZE, 16, signed sample and output width
- WEIGHT_SIZE, 16, signed weight width (fixed point, FRAC_BITS fraction bits)
- ADDITION_SIZE, 32, signed accumulator width
- NUM_INPUTS, 3, taps per channel (delay-line depth)
- NUM_SIGS, 2, input channels = output neurons
- FRAC_BITS, 8, weight fraction bits; result = acc >>> FRAC_BITS
- CLOCK_N  in  1  clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- SIG_IN  in  NUM_SIGS*SIG_SIZE  channel c at bits [c*SIG_SIZE +: SIG_SIZE]
- SIG_VALID  in  1  sample offered
- SIG_READY  out  1  sample accepted when SIG_VALID & SIG_READY
- wb_en  in  1  1 = weighted mode, 0 = bypass mode; sampled at accept
- WB_WE  in  1  weight write strobe
- WB_ADDR  in  clog2(NUM_SIGS*NUM_SIGS*NUM_INPUTS)  weight index ((o*NUM_SIGS+c)*NUM_INPUTS+k)
- WB_DATA  in  WEIGHT_SIZE  weight value
- SIG_OUT  out  NUM_SIGS*SIG_SIZE  neuron o at bits [o*SIG_SIZE +: SIG_SIZE]
- OUT_VALID  out  1  one-cycle pulse, SIG_OUT updated

## Operation
- Reset: state IDLE; delay lines, weights, accumulator, SIG_OUT all 0; OUT_VALID=0; SIG_READY=1.
- States: IDLE, MAC, DONE.
- IDLE: SIG_READY=1. On accept, every delay line shifts (tap 0 ← new sample, tap k ← tap k-1, oldest dropped), acc←0, index←0; wb_en=1 → MAC, wb_en=0 → DONE.
- MAC: SIG_READY=0. Each cycle, acc += w[o][c][k]*x[c][k]; index runs k fastest, then c, then o. After the last (c,k) of neuron o: SIG_OUT[o] ← sat(acc_final >>> FRAC_BITS), acc←0. After the last o → DONE.
- DONE: OUT_VALID=1, SIG_READY=0; next state IDLE. In bypass, SIG_OUT[o] ← tap 0 of channel o on entry to DONE.
- Arithmetic: signed product SIG_SIZE+WEIGHT_SIZE bits, sign-extended. Accumulation saturates at ±ADDITION_SIZE limits rather than wrapping. Shift is arithmetic (floor toward -inf). Output saturates to [-2^(SIG_SIZE-1), 2^(SIG_SIZE-1)-1].
- Weights: a WB_WE write takes effect at the edge. It is accepted in IDLE and DONE only. A write in MAC, or to an address ≥ NUM_SIGS*NUM_SIGS*NUM_INPUTS, is ignored.
- SIG_VALID outside IDLE has no effect; the source holds the sample until it is accepted.
- SIG_OUT holds its last value between results. Outputs of later neurons keep their old values until those neurons are written.
- RESET during any state forces the reset values at that edge, and the partial result is discarded.

## Timing
- Let N = NUM_SIGS*NUM_SIGS*NUM_INPUTS (default 12).
- Weighted mode: accept at edge 0. MAC occupies edges 1..N. OUT_VALID is high in the cycle after edge N, i.e. N+1 cycles after accept (default 13). SIG_READY returns high one cycle later. Throughput is one sample per N+2 cycles.
- Bypass: OUT_VALID is high in the cycle after the accept edge. The next accept is possible 2 cycles after the previous one.
- The delay-line shift and the first MAC operand read never overlap. The MAC always uses the post-shift taps.

## Test plan
- Delay line: set w[0][0][0]=256, w[1][1][2]=256, others 0; feed (ch0,ch1) = (100,7), (200,8), (300,9) → after 3rd sample SIG_OUT0=300, SIG_OUT1=7, with OUT_VALID 13 cycles after each accept.
- Saturation and rounding: w[0][0][0]=0x7FFF, sample 32767 → SIG_OUT0=32767; sample -32768 → -32768; w[0][0][0]=128, sample -3 → SIG_OUT0=-2.
- Bypass: wb_en=0, sample (-5,42) → SIG_OUT=(-5,42) with OUT_VALID 1 cycle after accept; SIG_READY high again in the next cycle.
- Busy protection: write w[0][0][0]=999 during MAC → ignored, result unchanged; SIG_VALID held throughout MAC → accepted only on return to IDLE.
- Reset mid-MAC: assert RESET at MAC cycle 5 → next cycle SIG_OUT=0, OUT_VALID=0, SIG_READY=1, weights 0; then feed (1,1) → SIG_OUT=(0,0).
- Out-of-range write to WB_ADDR=12 (defaults) → no weight changes; output equals the all-zero-weight result.

Source files
------------

// File: rtl/tdnn_layer_seq.sv
// ---------------------------------------------------------------------------
// tdnn_layer_seq
//
// Time-multiplexed time-delay neural network layer. Each of NUM_SIGS input
// channels keeps a NUM_INPUTS-deep delay line. Every output neuron o is the
// weighted sum over all channels c and taps k of w[o][c][k]*x[c][k]. One
// shared signed multiply-accumulate is used, one product per cycle. The
// accumulator and the outputs saturate instead of wrapping.
//
// Ports
//   CLOCK_N    clock, all logic on the rising edge
//   RESET      synchronous active-high reset
//   SIG_IN     packed samples, channel c at [c*SIG_SIZE +: SIG_SIZE]
//   SIG_VALID  sample offered
//   SIG_READY  high in IDLE; a sample is taken when SIG_VALID & SIG_READY
//   wb_en      1 = weighted mode, 0 = bypass (sampled at accept)
//   WB_WE      weight write strobe (honoured in IDLE and DONE only)
//   WB_ADDR    weight index (o*NUM_SIGS + c)*NUM_INPUTS + k
//   WB_DATA    signed weight value, FRAC_BITS fraction bits
//   SIG_OUT    packed results, neuron o at [o*SIG_SIZE +: SIG_SIZE]
//   OUT_VALID  one-cycle pulse when SIG_OUT has been updated
// ---------------------------------------------------------------------------
module tdnn_layer_seq #(
    parameter int SIG_SIZE      = 16,
    parameter int WEIGHT_SIZE   = 16,
    parameter int ADDITION_SIZE = 32,
    parameter int NUM_INPUTS    = 3,
    parameter int NUM_SIGS      = 2,
    parameter int FRAC_BITS     = 8,
    localparam int NUM_W        = NUM_SIGS * NUM_SIGS * NUM_INPUTS,
    localparam int AW           = (NUM_W > 1) ? $clog2(NUM_W) : 1
) (
    input  logic                         CLOCK_N,
    input  logic                         RESET,
    input  logic [NUM_SIGS*SIG_SIZE-1:0] SIG_IN,
    input  logic                         SIG_VALID,
    output logic                         SIG_READY,
    input  logic                         wb_en,
    input  logic                         WB_WE,
    input  logic [AW-1:0]                WB_ADDR,
    input  logic [WEIGHT_SIZE-1:0]       WB_DATA,
    output logic [NUM_SIGS*SIG_SIZE-1:0] SIG_OUT,
    output logic                         OUT_VALID
);

    localparam int KW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int CW = (NUM_SIGS > 1) ? $clog2(NUM_SIGS) : 1;
    localparam int PW = SIG_SIZE + WEIGHT_SIZE;
    // Sum width: one guard bit above the wider of accumulator and product
    localparam int EW = ((PW > ADDITION_SIZE) ? PW : ADDITION_SIZE) + 1;

    localparam logic [KW-1:0] K_LAST = KW'(NUM_INPUTS - 1);
    localparam logic [CW-1:0] C_LAST = CW'(NUM_SIGS - 1);

    localparam logic signed [EW-1:0] ACC_MAX =
        {{(EW - ADDITION_SIZE + 1){1'b0}}, {(ADDITION_SIZE - 1){1'b1}}};
    localparam logic signed [EW-1:0] ACC_MIN = ~ACC_MAX;
    localparam logic signed [ADDITION_SIZE-1:0] SIG_MAX =
        {{(ADDITION_SIZE - SIG_SIZE + 1){1'b0}}, {(SIG_SIZE - 1){1'b1}}};
    localparam logic signed [ADDITION_SIZE-1:0] SIG_MIN = ~SIG_MAX;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic signed [SIG_SIZE-1:0]      taps_reg [NUM_SIGS][NUM_INPUTS];
    logic signed [WEIGHT_SIZE-1:0]   weights_reg [NUM_W];
    logic signed [SIG_SIZE-1:0]      out_reg [NUM_SIGS];
    logic signed [ADDITION_SIZE-1:0] acc_reg;
    logic [AW-1:0]                   idx_reg;
    logic [KW-1:0]                   k_reg;
    logic [CW-1:0]                   c_reg;
    logic [CW-1:0]                   o_reg;

    logic signed [SIG_SIZE-1:0]      sig_in_ch [NUM_SIGS];
    logic [NUM_W-1:0]                we_vec;
    logic                            accept;
    logic                            wb_write_ok;
    logic                            last_ck;
    logic                            last_o;

    logic signed [SIG_SIZE-1:0]      tap_op;
    logic signed [WEIGHT_SIZE-1:0]   w_op;
    logic signed [PW-1:0]            prod;
    logic signed [EW-1:0]            sum_ext;
    logic signed [ADDITION_SIZE-1:0] acc_sat;
    logic signed [ADDITION_SIZE-1:0] acc_shift;
    logic signed [SIG_SIZE-1:0]      out_sat;

    // ---------------------------------------------------------------------
    // Channel unpacking, output packing and per-weight write enables
    // ---------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_SIGS; gi++) begin : g_chan
            assign sig_in_ch[gi] = SIG_IN[gi*SIG_SIZE +: SIG_SIZE];
            assign SIG_OUT[gi*SIG_SIZE +: SIG_SIZE] = out_reg[gi];
        end
        for (genvar gi = 0; gi < NUM_W; gi++) begin : g_we
            assign we_vec[gi] = wb_write_ok && (WB_ADDR == AW'(gi));
        end
    endgenerate

    assign accept      = SIG_VALID && (state_reg == IDLE);
    // Weights must not change while the MAC is reading them
    assign wb_write_ok = WB_WE && (state_reg != MAC)
                         && ({1'b0, WB_ADDR} < (AW + 1)'(NUM_W));
    assign last_ck     = (k_reg == K_LAST) && (c_reg == C_LAST);
    assign last_o      = (o_reg == C_LAST);

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge CLOCK_N) begin
        if (RESET) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        SIG_READY  = 1'b0;
        OUT_VALID  = 1'b0;
        case (state_reg)
            IDLE: begin
                SIG_READY = 1'b1;
                if (SIG_VALID) begin
                    state_next = wb_en ? MAC : DONE;
                end
            end
            MAC: begin
                if (last_ck && last_o) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                OUT_VALID  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Multiply-accumulate datapath with saturation
    // ---------------------------------------------------------------------
    always_comb begin
        tap_op  = taps_reg[c_reg][k_reg];
        w_op    = weights_reg[idx_reg];
        prod    = PW'(tap_op) * PW'(w_op);
        sum_ext = EW'(acc_reg) + EW'(prod);
        if (sum_ext > ACC_MAX) begin
            acc_sat = ADDITION_SIZE'(ACC_MAX);
        end else if (sum_ext < ACC_MIN) begin
            acc_sat = ADDITION_SIZE'(ACC_MIN);
        end else begin
            acc_sat = ADDITION_SIZE'(sum_ext);
        end
        // Arithmetic shift floors toward -inf
        acc_shift = acc_sat >>> FRAC_BITS;
        if (acc_shift > SIG_MAX) begin
            out_sat = SIG_SIZE'(SIG_MAX);
        end else if (acc_shift < SIG_MIN) begin
            out_sat = SIG_SIZE'(SIG_MIN);
        end else begin
            out_sat = SIG_SIZE'(acc_shift);
        end
    end

    // Index counters: flat weight index plus k (fastest), c, o
    always_ff @(posedge CLOCK_N) begin
        if (RESET) begin
            acc_reg <= '0;
            idx_reg <= '0;
            k_reg   <= '0;
            c_reg   <= '0;
            o_reg   <= '0;
        end else if (accept) begin
            acc_reg <= '0;
            idx_reg <= '0;
            k_reg   <= '0;
            c_reg   <= '0;
            o_reg   <= '0;
        end else if (state_reg == MAC) begin
            idx_reg <= idx_reg + 1'b1;
            if (k_reg == K_LAST) begin
                k_reg <= '0;
                if (c_reg == C_LAST) begin
                    c_reg   <= '0;
                    o_reg   <= o_reg + 1'b1;
                    acc_reg <= '0;
                end else begin
                    c_reg   <= c_reg + 1'b1;
                    acc_reg <= acc_sat;
                end
            end else begin
                k_reg   <= k_reg + 1'b1;
                acc_reg <= acc_sat;
            end
        end
    end

    // Delay lines shift only on accept, so the MAC always sees post-shift taps
    always_ff @(posedge CLOCK_N) begin
        if (RESET) begin
            for (int c = 0; c < NUM_SIGS; c++) begin
                for (int k = 0; k < NUM_INPUTS; k++) begin
                    taps_reg[c][k] <= '0;
                end
            end
        end else if (accept) begin
            for (int c = 0; c < NUM_SIGS; c++) begin
                taps_reg[c][0] <= sig_in_ch[c];
                for (int k = 1; k < NUM_INPUTS; k++) begin
                    taps_reg[c][k] <= taps_reg[c][k-1];
                end
            end
        end
    end

    always_ff @(posedge CLOCK_N) begin
        if (RESET) begin
            for (int i = 0; i < NUM_W; i++) begin
                weights_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_W; i++) begin
                if (we_vec[i]) begin
                    weights_reg[i] <= WB_DATA;
                end
            end
        end
    end

    // Bypass copies the fresh tap 0 (the incoming sample) straight out
    always_ff @(posedge CLOCK_N) begin
        if (RESET) begin
            for (int o = 0; o < NUM_SIGS; o++) begin
                out_reg[o] <= '0;
            end
        end else if (accept && !wb_en) begin
            for (int o = 0; o < NUM_SIGS; o++) begin
                out_reg[o] <= sig_in_ch[o];
            end
        end else if ((state_reg == MAC) && last_ck) begin
            out_reg[o_reg] <= out_sat;
        end
    end

endmodule

// File: tb/tb_tdnn_layer_seq.sv
// ---------------------------------------------------------------------------
// tb_tdnn_layer_seq
//
// Directed self-checking bench for tdnn_layer_seq with default parameters.
// Each scenario task drives stimulus and compares against hand-computed
// values. One line is printed per sample transaction.
// ---------------------------------------------------------------------------
module tb_tdnn_layer_seq;

    logic        clk;
    logic        rst;
    logic [31:0] sig_in;
    logic        sig_valid;
    logic        sig_ready;
    logic        wb_en;
    logic        wb_we;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic [31:0] sig_out;
    logic        out_valid;

    logic signed [15:0] out0;
    logic signed [15:0] out1;
    assign out0 = sig_out[15:0];
    assign out1 = sig_out[31:16];

    int checks = 0;
    int errors = 0;

    tdnn_layer_seq dut (
        .CLOCK_N   (clk),
        .RESET     (rst),
        .SIG_IN    (sig_in),
        .SIG_VALID (sig_valid),
        .SIG_READY (sig_ready),
        .wb_en     (wb_en),
        .WB_WE     (wb_we),
        .WB_ADDR   (wb_addr),
        .WB_DATA   (wb_data),
        .SIG_OUT   (sig_out),
        .OUT_VALID (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        rst = 1'b0;
    endtask

    task automatic write_w(input logic [3:0] addr, input logic [15:0] data);
        wb_we   = 1'b1;
        wb_addr = addr;
        wb_data = data;
        tick;
        wb_we   = 1'b0;
    endtask

    // Offer a sample, then count cycles from accept edge to OUT_VALID
    task automatic send(input logic signed [15:0] a, input logic signed [15:0] b,
                        input logic mode, output int lat);
        int w;
        w = 0;
        while (!sig_ready && w < 50) begin
            tick;
            w++;
        end
        sig_in    = {b, a};
        wb_en     = mode;
        sig_valid = 1'b1;
        tick;
        sig_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin
            tick;
            lat++;
        end
        $display("txn in=(%0d,%0d) mode=%0d latency=%0d out=(%0d,%0d)",
                 a, b, mode, lat, out0, out1);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        checks++;
        if (sig_out !== 32'd0) begin
            errors++;
            $display("FAIL reset_out: got %h expected 0", sig_out);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (sig_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1", sig_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_delay_line;
        int lat;
        logic signed [15:0] exp0 [3];
        logic signed [15:0] exp1 [3];
        logic signed [15:0] in0 [3];
        logic signed [15:0] in1 [3];
        in0 = '{16'sd100, 16'sd200, 16'sd300};
        in1 = '{16'sd7, 16'sd8, 16'sd9};
        exp0 = '{16'sd100, 16'sd200, 16'sd300};
        exp1 = '{16'sd0, 16'sd0, 16'sd7};
        do_reset;
        write_w(4'd0, 16'd256);
        write_w(4'd11, 16'd256);
        for (int i = 0; i < 3; i++) begin
            send(in0[i], in1[i], 1'b1, lat);
            checks++;
            if (lat !== 13) begin
                errors++;
                $display("FAIL delay_latency%0d: got %0d expected 13", i, lat);
            end
            checks++;
            if (out0 !== exp0[i] || out1 !== exp1[i]) begin
                errors++;
                $display("FAIL delay_out%0d: got (%0d,%0d) expected (%0d,%0d)",
                         i, out0, out1, exp0[i], exp1[i]);
            end
            checks++;
            if (sig_ready !== 1'b0) begin
                errors++;
                $display("FAIL delay_ready_done%0d: got %b expected 0", i, sig_ready);
            end
            tick;
            checks++;
            if (sig_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL delay_after%0d: got ready=%b valid=%b expected ready=1 valid=0",
                         i, sig_ready, out_valid);
            end
        end
    endtask

    task automatic test_saturation;
        int lat;
        do_reset;
        write_w(4'd0, 16'h7FFF);
        send(16'sd32767, 16'sd0, 1'b1, lat);
        checks++;
        if (out0 !== 16'sd32767) begin
            errors++;
            $display("FAIL sat_pos: got %0d expected 32767", out0);
        end
        send(-16'sd32768, 16'sd0, 1'b1, lat);
        checks++;
        if (out0 !== -16'sd32768) begin
            errors++;
            $display("FAIL sat_neg: got %0d expected -32768", out0);
        end
        tick;
        write_w(4'd0, 16'd128);
        send(-16'sd3, 16'sd0, 1'b1, lat);
        checks++;
        if (out0 !== -16'sd2) begin
            errors++;
            $display("FAIL floor_shift: got %0d expected -2", out0);
        end
        checks++;
        if (out1 !== 16'sd0) begin
            errors++;
            $display("FAIL sat_out1: got %0d expected 0", out1);
        end
    endtask

    task automatic test_bypass;
        int lat;
        do_reset;
        write_w(4'd0, 16'd256);
        send(-16'sd5, 16'sd42, 1'b0, lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL bypass_latency: got %0d expected 1", lat);
        end
        checks++;
        if (out0 !== -16'sd5 || out1 !== 16'sd42) begin
            errors++;
            $display("FAIL bypass_out: got (%0d,%0d) expected (-5,42)", out0, out1);
        end
        tick;
        checks++;
        if (sig_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bypass_ready: got ready=%b valid=%b expected ready=1 valid=0",
                     sig_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        // Bypass sample accepted immediately after the previous one returns
        send(16'sd7, -16'sd9, 1'b0, lat);
        checks++;
        if (lat !== 1 || out0 !== 16'sd7 || out1 !== -16'sd9) begin
            errors++;
            $display("FAIL b2b_bypass: got lat=%0d out=(%0d,%0d) expected lat=1 out=(7,-9)",
                     lat, out0, out1);
        end
        // Weighted sample sees the bypass taps shifted: ch0 tap0=11, tap1=7
        tick;
        send(16'sd11, 16'sd0, 1'b1, lat);
        checks++;
        if (lat !== 13 || out0 !== 16'sd11 || out1 !== 16'sd0) begin
            errors++;
            $display("FAIL b2b_weighted: got lat=%0d out=(%0d,%0d) expected lat=13 out=(11,0)",
                     lat, out0, out1);
        end
    endtask

    task automatic test_busy;
        int lat;
        int lat2;
        do_reset;
        write_w(4'd0, 16'd256);
        sig_in    = {16'sd20, 16'sd10};
        wb_en     = 1'b1;
        sig_valid = 1'b1;
        tick;
        // Next sample offered and held through the whole MAC
        sig_in = {16'sd60, 16'sd50};
        lat = 1;
        while (!out_valid && lat < 50) begin
            if (lat == 3) begin
                wb_we   = 1'b1;
                wb_addr = 4'd0;
                wb_data = 16'd999;
            end
            tick;
            wb_we = 1'b0;
            lat++;
        end
        $display("txn in=(10,20) mode=1 latency=%0d out=(%0d,%0d)", lat, out0, out1);
        checks++;
        if (lat !== 13) begin
            errors++;
            $display("FAIL busy_latency: got %0d expected 13", lat);
        end
        checks++;
        if (out0 !== 16'sd10 || out1 !== 16'sd0) begin
            errors++;
            $display("FAIL busy_write_ignored: got (%0d,%0d) expected (10,0)", out0, out1);
        end
        tick;
        checks++;
        if (sig_ready !== 1'b1) begin
            errors++;
            $display("FAIL busy_ready_idle: got %b expected 1", sig_ready);
        end
        tick;
        sig_valid = 1'b0;
        lat2 = 1;
        while (!out_valid && lat2 < 50) begin
            tick;
            lat2++;
        end
        $display("txn in=(50,60) mode=1 latency=%0d out=(%0d,%0d)", lat2, out0, out1);
        checks++;
        if (lat2 !== 13 || out0 !== 16'sd50) begin
            errors++;
            $display("FAIL busy_held_sample: got lat=%0d out0=%0d expected lat=13 out0=50",
                     lat2, out0);
        end
    endtask

    task automatic test_reset_mid_mac;
        int lat;
        do_reset;
        write_w(4'd0, 16'd256);
        write_w(4'd11, 16'd256);
        send(16'sd100, 16'sd7, 1'b1, lat);
        checks++;
        if (out0 !== 16'sd100) begin
            errors++;
            $display("FAIL rmm_pre: got %0d expected 100", out0);
        end
        tick;
        sig_in    = {16'sd8, 16'sd200};
        wb_en     = 1'b1;
        sig_valid = 1'b1;
        tick;
        sig_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++;
        if (sig_out !== 32'd0 || out_valid !== 1'b0 || sig_ready !== 1'b1) begin
            errors++;
            $display("FAIL rmm_state: got out=%h valid=%b ready=%b expected out=0 valid=0 ready=1",
                     sig_out, out_valid, sig_ready);
        end
        send(16'sd1, 16'sd1, 1'b1, lat);
        checks++;
        if (lat !== 13 || out0 !== 16'sd0 || out1 !== 16'sd0) begin
            errors++;
            $display("FAIL rmm_weights_cleared: got lat=%0d out=(%0d,%0d) expected lat=13 out=(0,0)",
                     lat, out0, out1);
        end
    endtask

    task automatic test_out_of_range;
        int lat;
        do_reset;
        write_w(4'd12, 16'd256);
        write_w(4'd15, 16'd256);
        send(16'sd100, 16'sd100, 1'b1, lat);
        checks++;
        if (out0 !== 16'sd0 || out1 !== 16'sd0) begin
            errors++;
            $display("FAIL oor_write: got (%0d,%0d) expected (0,0)", out0, out1);
        end
        // A valid write right after still lands
        tick;
        write_w(4'd3, 16'd512);
        send(16'sd5, 16'sd0, 1'b1, lat);
        checks++;
        if (out0 !== 16'sd0 || out1 !== 16'sd0) begin
            errors++;
            $display("FAIL oor_w3_ch1: got (%0d,%0d) expected (0,0)", out0, out1);
        end
        tick;
        send(16'sd0, 16'sd6, 1'b1, lat);
        checks++;
        if (out0 !== 16'sd12 || out1 !== 16'sd0) begin
            errors++;
            $display("FAIL oor_w3_valid: got (%0d,%0d) expected (12,0)", out0, out1);
        end
    endtask

    initial begin
        rst       = 1'b0;
        sig_in    = '0;
        sig_valid = 1'b0;
        wb_en     = 1'b1;
        wb_we     = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        test_reset;
        test_delay_line;
        test_saturation;
        test_bypass;
        test_back_to_back;
        test_busy;
        test_reset_mid_mac;
        test_out_of_range;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
